// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter controller.
// Next-PC source select, default vectors, alignment mask helper.
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_EXC,
    SRC_ERET,
    SRC_REDIR,
    SRC_RET,
    SRC_HOLD,
    SRC_SEQ
  } pc_src_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

  // Mask that clears the sub-instruction address bits.
  function automatic logic [63:0] align_mask(input int inst_bytes);
    logic [63:0] m;
    m = 64'(inst_bytes) - 64'd1;
    return ~m;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest
// entry, and the count saturates at the stack depth.
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [XLEN-1:0]          push_data,
  output logic [XLEN-1:0]          top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  import pc_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   top_idx;

  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);

  // Pointer and occupancy; ptr is the next slot to write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (count != CW'(DEPTH))
        count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: prioritised next-PC select, EPC capture,
// return-address stack and one-cycle misalign/underflow pulses.
module pc_ctrl #(
  parameter int          XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(32'h0000_0080),
  parameter int          INST_BYTES = 4,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  input  logic                        call_valid,
  input  logic                        ret_valid,
  input  logic                        exc_valid,
  input  logic [XLEN-1:0]             exc_pc,
  input  logic                        eret_valid,
  output logic [XLEN-1:0]             pc_current,
  output logic [XLEN-1:0]             pc_plus,
  output logic [XLEN-1:0]             epc,
  output logic                        misalign,
  output logic                        ras_underflow,
  output logic [$clog2(RAS_DEPTH):0]  ras_count
);
  import pc_pkg::*;

  localparam logic [63:0]     MASK64 = align_mask(INST_BYTES);
  localparam logic [XLEN-1:0] MASK   = MASK64[XLEN-1:0];

  pc_src_e         src;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            push;
  logic            pop;
  logic            clear;
  logic            redir_mis;

  assign pc_plus   = pc_current + XLEN'(INST_BYTES);
  assign redir_mis = |(redirect_pc & ~MASK);

  // Priority select of the next-PC source and RAS side effects.
  always_comb begin
    src     = SRC_SEQ;
    pc_next = pc_plus;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    if (exc_valid) begin
      src     = SRC_EXC;
      pc_next = EXC_VEC;
      clear   = 1'b1;
    end else if (eret_valid) begin
      src     = SRC_ERET;
      pc_next = epc;
    end else if (redirect_valid) begin
      src     = SRC_REDIR;
      pc_next = redirect_pc & MASK;
      push    = call_valid;
    end else if (ret_valid) begin
      src = SRC_RET;
      if (!ras_empty) begin
        pc_next = ras_top;
        pop     = 1'b1;
      end
    end else if (stall) begin
      src     = SRC_HOLD;
      pc_next = pc_current;
    end
  end

  // PC, EPC and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_current    <= RESET_VEC;
      epc           <= '0;
      misalign      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc_current    <= pc_next;
      misalign      <= (src == SRC_REDIR) && redir_mis;
      ras_underflow <= (src == SRC_RET) && ras_empty;
      if (src == SRC_EXC)
        epc <= exc_pc;
    end
  end

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .push_data (pc_plus),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl; expected state is queued when stimulus is
// driven and popped/compared one clock later.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        call_valid;
  logic        ret_valid;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        eret_valid;
  logic [31:0] pc_current;
  logic [31:0] pc_plus;
  logic [31:0] epc;
  logic        misalign;
  logic        ras_underflow;
  logic [2:0]  ras_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        mis;
    logic        unf;
    logic [2:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .call_valid     (call_valid),
    .ret_valid      (ret_valid),
    .exc_valid      (exc_valid),
    .exc_pc         (exc_pc),
    .eret_valid     (eret_valid),
    .pc_current     (pc_current),
    .pc_plus        (pc_plus),
    .epc            (epc),
    .misalign       (misalign),
    .ras_underflow  (ras_underflow),
    .ras_count      (ras_count)
  );

  task automatic cmp(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    call_valid     = 1'b0;
    ret_valid      = 1'b0;
    exc_valid      = 1'b0;
    exc_pc         = '0;
    eret_valid     = 1'b0;
  endtask

  // Queue the expected post-edge state, clock once, then compare.
  task automatic step(input string tag, input logic [31:0] pc,
                      input logic [31:0] e, input logic mis,
                      input logic unf, input logic [2:0] cnt);
    exp_t x;
    exp_t y;
    x.pc = pc; x.epc = e; x.mis = mis; x.unf = unf; x.cnt = cnt;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    y = exp_q.pop_front();
    cmp({tag, ".pc"},  pc_current, y.pc);
    cmp({tag, ".epc"}, epc, y.epc);
    cmp({tag, ".mis"}, 32'(misalign), 32'(y.mis));
    cmp({tag, ".unf"}, 32'(ras_underflow), 32'(y.unf));
    cmp({tag, ".cnt"}, 32'(ras_count), 32'(y.cnt));
    idle_in();
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    #3;
    cmp("rst_pc", pc_current, 32'h0);
    cmp("rst_epc", epc, 32'h0);
    cmp("rst_cnt", 32'(ras_count), 32'h0);
    cmp("rst_flags", 32'({misalign, ras_underflow}), 32'h0);
    #9 rst = 1'b0;

    step("seq1", 32'h4, 0, 0, 0, 0);
    step("seq2", 32'h8, 0, 0, 0, 0);
    step("seq3", 32'hC, 0, 0, 0, 0);

    #2 rst = 1'b1;
    #1 cmp("async_rst_pc", pc_current, 32'h0);
    #2 rst = 1'b0;

    redirect_valid = 1; redirect_pc = 32'h44;
    step("to44", 32'h44, 0, 0, 0, 0);
    exc_valid = 1; exc_pc = 32'h40;
    step("exc", 32'h80, 32'h40, 0, 0, 0);
    eret_valid = 1;
    step("eret", 32'h40, 32'h40, 0, 0, 0);
    exc_valid = 1; exc_pc = 32'h48; eret_valid = 1;
    step("exc_eret", 32'h80, 32'h48, 0, 0, 0);

    redirect_valid = 1; redirect_pc = 32'h103;
    step("mis_redir", 32'h100, 32'h48, 1, 0, 0);
    step("mis_clear", 32'h104, 32'h48, 0, 0, 0);
    redirect_valid = 1; redirect_pc = 32'h200; stall = 1;
    step("redir_stall", 32'h200, 32'h48, 0, 0, 0);
    stall = 1;
    step("stall", 32'h200, 32'h48, 0, 0, 0);

    redirect_valid = 1; redirect_pc = 32'h10;
    step("to10", 32'h10, 32'h48, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      redirect_valid = 1; call_valid = 1;
      redirect_pc = 32'h10 + 32'(i) * 32'h10;
      step("call", 32'h10 + 32'(i) * 32'h10, 32'h48, 0, 0,
           3'((i > 4) ? 4 : i));
    end
    ret_valid = 1;
    step("ret1", 32'h54, 32'h48, 0, 0, 3);
    ret_valid = 1;
    step("ret2", 32'h44, 32'h48, 0, 0, 2);
    ret_valid = 1;
    step("ret3", 32'h34, 32'h48, 0, 0, 1);
    ret_valid = 1;
    step("ret4", 32'h24, 32'h48, 0, 0, 0);
    ret_valid = 1;
    step("ret_unf", 32'h28, 32'h48, 0, 1, 0);
    step("unf_clear", 32'h2C, 32'h48, 0, 0, 0);
    call_valid = 1;
    step("call_alone", 32'h30, 32'h48, 0, 0, 0);

    redirect_valid = 1; call_valid = 1; redirect_pc = 32'h100;
    step("c1", 32'h100, 32'h48, 0, 0, 1);
    redirect_valid = 1; call_valid = 1; redirect_pc = 32'h200;
    step("c2", 32'h200, 32'h48, 0, 0, 2);
    redirect_valid = 1; call_valid = 1; redirect_pc = 32'h300;
    step("c3", 32'h300, 32'h48, 0, 0, 3);
    ret_valid = 1; redirect_valid = 1; redirect_pc = 32'h400;
    step("ret_vs_redir", 32'h400, 32'h48, 0, 0, 3);
    ret_valid = 1; stall = 1;
    step("ret_stall", 32'h204, 32'h48, 0, 0, 2);
    exc_valid = 1; exc_pc = 32'h11;
    redirect_valid = 1; call_valid = 1; redirect_pc = 32'h13;
    step("exc_clear", 32'h80, 32'h11, 0, 0, 0);

    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step("to_top", 32'hFFFF_FFFC, 32'h11, 0, 0, 0);
    cmp("pc_plus_wrap", pc_plus, 32'h0);
    step("wrap", 32'h0, 32'h11, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Parametrised program-counter controller; next generation of the plain PC register.
- Holds the current fetch PC and selects the next PC from exception, exception-return, redirect, return-address-stack pop, stall or sequential sources.
- Keeps an EPC register and a small circular return-address stack (RAS).
- Sits between the branch/exception logic and instruction fetch.

Parameters:
XLEN, 32, PC and address width in bits.
RESET_VEC, 32'h0000_0000, PC value loaded on reset.
EXC_VEC, 32'h0000_0080, PC value loaded on exception entry.
INST_BYTES, 4, sequential increment; power of 2; also sets the alignment mask.
RAS_DEPTH, 4, RAS entries; power of 2, at least 2.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  hold the PC; lowest priority after ret.
redirect_valid  in  1  branch/jump taken.
redirect_pc  in  XLEN  redirect target.
call_valid  in  1  qualifies the redirect as a call; push pc_current+INST_BYTES.
ret_valid  in  1  predicted return; pop the RAS.
exc_valid  in  1  exception entry.
exc_pc  in  XLEN  faulting PC, captured into epc.
eret_valid  in  1  return from exception.
pc_current  out  XLEN  current fetch PC (registered).
pc_plus  out  XLEN  pc_current+INST_BYTES (combinational, modulo 2^XLEN).
epc  out  XLEN  saved exception PC (registered).
misalign  out  1  one-cycle pulse: last redirect target was misaligned.
ras_underflow  out  1  one-cycle pulse: ret with empty RAS.
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.

Behaviour:
- Reset, asynchronous, immediate:
  - pc_current=RESET_VEC, epc=0, misalign=0, ras_underflow=0, ras_count=0.
  - RAS pointer=0. RAS contents need no reset.
- Update latency: one clock. Sources are sampled at a rising edge and pc_current holds the new value after that edge.
- Next-PC priority, highest first:
  1. exc_valid: pc<=EXC_VEC; epc<=exc_pc; ras_count<=0.
  2. eret_valid: pc<=epc, using the value before this edge.
  3. redirect_valid: pc<=redirect_pc with low log2(INST_BYTES) bits forced to 0.
     - If any cleared bit was 1, misalign=1 for the next cycle.
     - If call_valid is also high, push pc_plus.
  4. ret_valid with ras_count>0: pc<=top entry; pop.
  5. ret_valid with ras_count==0: pc<=pc_plus; ras_underflow=1 for the next cycle.
  6. stall: pc holds.
  7. Otherwise: pc<=pc_plus.
- Stall interaction: exc, eret and redirect override stall. Under stall, ret is ignored only if stall is asserted without ret; ret is evaluated before stall. Consequence: a ret during stall still pops.
- Ignored inputs: call_valid without redirect_valid is ignored. Lower-priority requests in the same cycle are dropped with no side effects. Examples: a redirect losing to exc does not push; a ret losing to a redirect does not pop.
- RAS:
  - Circular buffer with a top pointer.
  - Push when full overwrites the oldest entry; ras_count saturates at RAS_DEPTH and the pointer wraps modulo RAS_DEPTH.
  - Pop decrements ras_count; the pointer wraps backward.
- Arithmetic: pc_plus wraps modulo 2^XLEN (32'hFFFF_FFFC+4 = 0).
- Pulses: misalign and ras_underflow are 1 for exactly one cycle per event and 0 otherwise.
- exc and eret in the same cycle: exc wins; epc takes exc_pc.

Decomposition:
- Shared package pc_pkg holds:
  - next-PC source select enum (SRC_EXC, SRC_ERET, SRC_REDIR, SRC_RET, SRC_HOLD, SRC_SEQ);
  - default RESET_VEC/EXC_VEC constants;
  - an alignment-mask function.
- One sub-module, pc_ras: the parametrised circular stack with push, pop, clear, top, count and empty. The top level holds the priority mux, the PC and EPC registers, and the pulse flags.

Test Plan:
- Reset release with no inputs for 3 cycles -> pc_current goes 0x0 -> 0x4 -> 0x8 -> 0xC. Assert rst mid-run -> pc_current becomes 0x0 immediately, before the next clock edge.
- exc_valid with exc_pc=0x40 while pc=0x44 -> pc=0x80 and epc=0x40. Then eret_valid -> pc=0x40. exc+eret in the same cycle -> pc=0x80.
- redirect_pc=0x103 -> pc=0x100 and misalign pulses for 1 cycle. redirect_valid together with stall -> redirect taken.
- Five call redirects from pc=0x10,0x20,0x30,0x40,0x50 (RAS_DEPTH=4) -> ras_count=4. Four rets -> pc=0x54,0x44,0x34,0x24. A fifth ret -> pc=pc_plus and ras_underflow pulses.
- ret_valid with redirect_valid=1 -> redirect taken and ras_count unchanged. exc with ras_count=3 -> ras_count=0.
- pc=0xFFFF_FFFC with no inputs -> next pc=0x0000_0000.
